// File: rtl/comb_sequencer.sv
// comb_sequencer
//
// Initiator for one combinational Comb operator. When start is accepted in
// IDLE, the sequencer latches one operand byte and sweeps every
// {op, cst} combination, with op as the outer loop and cst as the inner loop.
// Each Comb response is registered and offered downstream over a
// valid/ready handshake. A per-sweep count of status=1 results is kept.
//
// Optional build macro: COMB_SEQ_SIGNATURE_EN
//   defined   : signature accumulates rotate-left-by-1 XOR comb_output on
//               every capture; it is cleared on start and on reset.
//   undefined : no signature register is built; signature is tied to 0.
//
// Ports
//   clk          : single clock, rising edge
//   reset_n      : synchronous active-low reset
//   start        : begin a sweep (honoured only in IDLE)
//   in_byte      : operand, latched on an accepted start
//   busy         : high in every state except IDLE
//   done         : one-cycle pulse after the last result is accepted
//   comb_input   : to Comb MyInput (latched operand)
//   comb_cst     : to Comb MyConstantSelect
//   comb_op      : to Comb MyOperation
//   comb_output  : from Comb MyOutput
//   comb_status  : from Comb MyStatus
//   res_valid    : result registers hold an unconsumed result
//   res_ready    : downstream accepts the result
//   res_data     : captured comb_output
//   res_status   : captured comb_status
//   res_op       : op that produced res_data
//   res_cst      : cst that produced res_data
//   status_count : status=1 results in the current/last sweep
//   signature    : rotate-XOR signature of the results (see macro above)

module comb_sequencer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned SEL_W  = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [DATA_W-1:0]    in_byte,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_W-1:0]    comb_input,
    output logic [SEL_W-1:0]     comb_cst,
    output logic [SEL_W-1:0]     comb_op,
    input  logic [DATA_W-1:0]    comb_output,
    input  logic                 comb_status,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [DATA_W-1:0]    res_data,
    output logic                 res_status,
    output logic [SEL_W-1:0]     res_op,
    output logic [SEL_W-1:0]     res_cst,
    output logic [2*SEL_W:0]     status_count,
    output logic [DATA_W-1:0]    signature
);

    localparam int unsigned IDX_W = 2 * SEL_W;
    localparam int unsigned CNT_W = 2 * SEL_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t              state_q,      state_d;
    logic [IDX_W-1:0]    idx_q,        idx_d;
    logic [DATA_W-1:0]   operand_q,    operand_d;
    logic                res_valid_q,  res_valid_d;
    logic [DATA_W-1:0]   res_data_q,   res_data_d;
    logic                res_status_q, res_status_d;
    logic [SEL_W-1:0]    res_op_q,     res_op_d;
    logic [SEL_W-1:0]    res_cst_q,    res_cst_d;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;
`ifdef COMB_SEQ_SIGNATURE_EN
    logic [DATA_W-1:0]   sig_q,        sig_d;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            operand_q    <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_status_q <= 1'b0;
            res_op_q     <= '0;
            res_cst_q    <= '0;
            cnt_q        <= '0;
`ifdef COMB_SEQ_SIGNATURE_EN
            sig_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            operand_q    <= operand_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_status_q <= res_status_d;
            res_op_q     <= res_op_d;
            res_cst_q    <= res_cst_d;
            cnt_q        <= cnt_d;
`ifdef COMB_SEQ_SIGNATURE_EN
            sig_q        <= sig_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        operand_d    = operand_q;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_status_d = res_status_q;
        res_op_d     = res_op_q;
        res_cst_d    = res_cst_q;
        cnt_d        = cnt_q;
`ifdef COMB_SEQ_SIGNATURE_EN
        sig_d        = sig_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    operand_d = in_byte;
                    idx_d     = '0;
                    cnt_d     = '0;
`ifdef COMB_SEQ_SIGNATURE_EN
                    sig_d     = '0;
`endif
                    state_d   = S_DRIVE;
                end
            end

            // Comb has had one full cycle to settle on the current index.
            S_DRIVE: begin
                res_data_d   = comb_output;
                res_status_d = comb_status;
                res_op_d     = idx_q[IDX_W-1:SEL_W];
                res_cst_d    = idx_q[SEL_W-1:0];
                res_valid_d  = 1'b1;
                if (comb_status) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`ifdef COMB_SEQ_SIGNATURE_EN
                sig_d = {sig_q[DATA_W-2:0], sig_q[DATA_W-1]} ^ comb_output;
`endif
                state_d = S_HOLD;
            end

            // Termination uses the last-index compare, so the index never wraps.
            S_HOLD: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    if (idx_q == '1) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_DRIVE;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign comb_input   = operand_q;
    assign comb_op      = idx_q[IDX_W-1:SEL_W];
    assign comb_cst     = idx_q[SEL_W-1:0];
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign res_status   = res_status_q;
    assign res_op       = res_op_q;
    assign res_cst      = res_cst_q;
    assign status_count = cnt_q;
`ifdef COMB_SEQ_SIGNATURE_EN
    assign signature    = sig_q;
`else
    assign signature    = '0;
`endif

endmodule
